// File: rtl/alu_pkg.sv
// Shared ALU function codes used by every stage that drives or decodes EXE_CMD.
package alu_pkg;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    RADD = 3'd1,
    RSUB = 3'd2,
    RSLL = 3'd3,
    RSRL = 3'd4
  } alu_cmd_e;

endpackage

// File: rtl/decode_pkg.sv
// Decode-stage definitions: opcode map, instruction field positions, register count.
package decode_pkg;

  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;

  localparam int OPC_MSB = 15, OPC_LSB = 13;
  localparam int RD_MSB  = 12, RD_LSB  = 10;
  localparam int RS1_MSB = 9,  RS1_LSB = 7;
  localparam int RS2_MSB = 6,  RS2_LSB = 4;
  localparam int IMM_MSB = 7,  IMM_LSB = 0;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_SLL  = 3'b011,
    OP_SRL  = 3'b100,
    OP_LDI  = 3'b101,
    OP_ILL6 = 3'b110,
    OP_ILL7 = 3'b111
  } opcode_e;

  function automatic logic reads_sources(opcode_e op);
    return op inside {OP_ADD, OP_SUB, OP_SLL, OP_SRL};
  endfunction

  // R0 is constant, so it can never be the subject of a hazard or bypass.
  function automatic logic src_hit(logic [REG_AW-1:0] src, logic [REG_AW-1:0] tgt);
    return (src != '0) && (src == tgt);
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 8 x DW register file: two combinational read ports, one write port, R0 reads zero.
module regfile
  import decode_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [DW-1:0]     rdata1_o,
  output logic [DW-1:0]     rdata2_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DW-1:0]     wdata_i
);

  logic [DW-1:0] mem_q [NUM_REGS];

  // NOTE: this array is small and must read as zero after reset, so it is
  // reset like ordinary flops; large RAMs would normally be left unreset.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: register read, hazard stall, registered ALU operands with valid/ready.
// Define DECODE_FWD_EN to bypass writeback data into the source reads.
module decode_stage
  import decode_pkg::*;
  import alu_pkg::*;
#(
  parameter int n = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instr,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [n-1:0]      a,
  output logic [n-1:0]      b,
  output logic [2:0]        EXE_CMD,
  output logic [2:0]        rd,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [n-1:0]      wb_data,
  output logic              illegal
);

  opcode_e           op;
  logic [REG_AW-1:0] f_rd, f_rs1, f_rs2;
  logic [7:0]        f_imm;
  logic              uses_src;

  assign op       = opcode_e'(instr[OPC_MSB:OPC_LSB]);
  assign f_rd     = instr[RD_MSB:RD_LSB];
  assign f_rs1    = instr[RS1_MSB:RS1_LSB];
  assign f_rs2    = instr[RS2_MSB:RS2_LSB];
  assign f_imm    = instr[IMM_MSB:IMM_LSB];
  assign uses_src = reads_sources(op);

  logic [n-1:0]      a_q, a_d, b_q, b_d;
  alu_cmd_e          cmd_q, cmd_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              valid_q, valid_d, illegal_q, illegal_d;

  logic [n-1:0] rf_rd1, rf_rd2, src1_val, src2_val;
  logic         stall, accept;

  regfile #(.DW(n)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .raddr1_i (f_rs1),
    .raddr2_i (f_rs2),
    .rdata1_o (rf_rd1),
    .rdata2_o (rf_rd2),
    .we_i     (wb_en),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data)
  );

`ifdef DECODE_FWD_EN
  // Only a held (not yet consumed) result can be missing; a consumed one arrives on wb.
  always_comb begin
    src1_val = src_hit(f_rs1, wb_addr) && wb_en ? wb_data : rf_rd1;
    src2_val = src_hit(f_rs2, wb_addr) && wb_en ? wb_data : rf_rd2;
    stall    = uses_src && valid_q && !out_ready &&
               (src_hit(f_rs1, rd_q) || src_hit(f_rs2, rd_q));
  end
`else
  always_comb begin
    src1_val = rf_rd1;
    src2_val = rf_rd2;
    stall    = uses_src &&
               ((valid_q && (src_hit(f_rs1, rd_q) || src_hit(f_rs2, rd_q))) ||
                (wb_en && (src_hit(f_rs1, wb_addr) || src_hit(f_rs2, wb_addr))));
  end
`endif

  assign in_ready = (!valid_q || out_ready) && !stall;
  assign accept   = in_valid && in_ready;

  // NOTE: every target gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    cmd_d     = cmd_q;
    rd_d      = rd_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    if (accept) begin
      valid_d = 1'b1;
      a_d     = '0;
      b_d     = '0;
      cmd_d   = NOP;
      rd_d    = '0;
      case (op)
        OP_ADD, OP_SUB, OP_SLL, OP_SRL: begin
          a_d  = src1_val;
          b_d  = src2_val;
          rd_d = f_rd;
          case (op)
            OP_ADD:  cmd_d = RADD;
            OP_SUB:  cmd_d = RSUB;
            OP_SLL:  cmd_d = RSLL;
            default: cmd_d = RSRL;
          endcase
        end
        OP_LDI: begin
          a_d   = n'(f_imm);
          cmd_d = RADD;
          rd_d  = f_rd;
        end
        OP_ILL6, OP_ILL7: illegal_d = 1'b1;
        default: ;
      endcase
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      cmd_q     <= NOP;
      rd_q      <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      cmd_q     <= cmd_d;
      rd_q      <= rd_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign EXE_CMD   = cmd_q;
  assign rd        = rd_q;
  assign out_valid = valid_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: instruction-level model compared every cycle,
// plus hand-computed literal expectations; a bench downstream performs writeback.
module tb_decode_stage;
  import alu_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [15:0]  instr = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a, b;
  logic [2:0]   EXE_CMD, rd;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         wb_en;
  logic [2:0]   wb_addr;
  logic [N-1:0] wb_data;
  logic         illegal;

  logic         auto_wb = 1'b1;
  logic         man_en = 1'b0;
  logic [2:0]   man_addr = '0;
  logic [N-1:0] man_data = '0;
  logic [N-1:0] alu_res;

  int n_tests = 0;
  int n_fail  = 0;

  decode_stage #(.n(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .EXE_CMD   (EXE_CMD),
    .rd        (rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Downstream executes the issued instruction and writes the result back when consumed.
  always_comb begin
    case (EXE_CMD)
      RADD:    alu_res = a + b;
      RSUB:    alu_res = a - b;
      RSLL:    alu_res = a << b;
      RSRL:    alu_res = a >> b;
      default: alu_res = '0;
    endcase
  end
  assign wb_en   = auto_wb ? (out_valid && out_ready && (EXE_CMD != NOP)) : man_en;
  assign wb_addr = auto_wb ? rd : man_addr;
  assign wb_data = auto_wb ? alu_res : man_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level model ----------------
  logic [N-1:0] m_rf [8];
  logic         m_valid = 1'b0, m_illegal = 1'b0;
  logic [N-1:0] m_a = '0, m_b = '0;
  logic [2:0]   m_cmd = 3'd0, m_rd = 3'd0, m_op;
  logic         m_acc;

  function automatic logic hit(logic [2:0] s, logic [2:0] t);
    return (s != 0) && (s == t);
  endfunction

  function automatic logic m_reads(logic [15:0] ins);
    return (ins[15:13] >= 3'd1) && (ins[15:13] <= 3'd4);
  endfunction

  function automatic logic m_stall();
    logic [2:0] s1, s2;
    s1 = instr[9:7];
    s2 = instr[6:4];
    if (!m_reads(instr)) return 1'b0;
`ifdef DECODE_FWD_EN
    return m_valid && !out_ready && (hit(s1, m_rd) || hit(s2, m_rd));
`else
    return (m_valid && (hit(s1, m_rd) || hit(s2, m_rd))) ||
           (wb_en && (hit(s1, wb_addr) || hit(s2, wb_addr)));
`endif
  endfunction

  function automatic logic [N-1:0] m_src(logic [2:0] s);
`ifdef DECODE_FWD_EN
    if (wb_en && hit(s, wb_addr)) return wb_data;
`endif
    return (s == 0) ? '0 : m_rf[s];
  endfunction

  function automatic logic m_in_ready();
    return (!m_valid || out_ready) && !m_stall();
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 0; m_illegal = 0; m_a = '0; m_b = '0; m_cmd = NOP; m_rd = 0;
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
    end else begin
      m_acc = in_valid && m_in_ready();
      if (m_acc) begin
        m_op = instr[15:13];
        m_valid = 1; m_a = '0; m_b = '0; m_cmd = NOP; m_rd = 0;
        if (m_reads(instr)) begin
          m_a  = m_src(instr[9:7]);
          m_b  = m_src(instr[6:4]);
          m_rd = instr[12:10];
          case (m_op)
            3'd1:    m_cmd = RADD;
            3'd2:    m_cmd = RSUB;
            3'd3:    m_cmd = RSLL;
            default: m_cmd = RSRL;
          endcase
        end else if (m_op == 3'd5) begin
          m_a   = N'(instr[7:0]);
          m_cmd = RADD;
          m_rd  = instr[12:10];
        end else if (m_op >= 3'd6) begin
          m_illegal = 1;
        end
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("cmp_in_ready", in_ready, m_in_ready());
      check("cmp_out_valid", out_valid, m_valid);
      check("cmp_illegal", illegal, m_illegal);
      if (m_valid) begin
        check("cmp_a", a, m_a);
        check("cmp_b", b, m_b);
        check("cmp_cmd", EXE_CMD, m_cmd);
        check("cmp_rd", rd, m_rd);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [15:0] ins);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    instr    = ins;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: instr %0h not accepted within 20 cycles", ins);
    end
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_illegal", illegal, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_cmd", EXE_CMD, NOP);
    cyc();

    // ADD r3,r1,r2 on a cleared register file
    send(16'h2CA0);
    @(negedge clk);
    check("add0_valid", out_valid, 1);
    check("add0_a", a, 0);
    check("add0_b", b, 0);
    check("add0_cmd", EXE_CMD, RADD);
    check("add0_rd", rd, 3);
    cyc();

    // LDI r1,0x05 then ADD r2,r1,r1 back to back
    in_valid = 1'b1;
    instr    = 16'hA405;
    @(negedge clk);
    check("ldi_in_ready", in_ready, 1);
    cyc();
    instr = 16'h2890;
    @(negedge clk);
    check("ldi_a", a, 8'h05);
    check("ldi_b", b, 0);
    check("ldi_rd", rd, 1);
`ifdef DECODE_FWD_EN
    check("raw_in_ready", in_ready, 1);
`else
    check("raw_in_ready", in_ready, 0);
    cyc();
    @(negedge clk);
    check("raw_stall_end_valid", out_valid, 0);
    check("raw_stall_end_ready", in_ready, 1);
`endif
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    check("raw_add_valid", out_valid, 1);
    check("raw_add_a", a, 8'h05);
    check("raw_add_b", b, 8'h05);
    check("raw_add_rd", rd, 2);
    cyc();

    // Backpressure on SUB r4,r2,r1 with LDI r5,0x33 waiting
    send(16'h5110);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 16'hB433;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_a", a, 8'h0A);
      check("bp_b", b, 8'h05);
      check("bp_cmd", EXE_CMD, RSUB);
      check("bp_rd", rd, 4);
      check("bp_in_ready", in_ready, 0);
      cyc();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_a", a, 8'h33);
    check("bp_next_rd", rd, 5);
    cyc();

    // Illegal opcode 110 is sticky
    send(16'hDC80);
    @(negedge clk);
    check("ill_cmd", EXE_CMD, NOP);
    check("ill_rd", rd, 0);
    check("ill_a", a, 0);
    check("ill_flag", illegal, 1);
    cyc();
    send(16'h2CA0);
    @(negedge clk);
    check("ill_add_a", a, 8'h05);
    check("ill_add_b", b, 8'h0A);
    check("ill_sticky", illegal, 1);
    cyc();
    cyc();

    // Write to R0 is ignored: ADD r1,r0,r0
    auto_wb  = 1'b0;
    man_en   = 1'b1;
    man_addr = 3'd0;
    man_data = 8'hAA;
    send(16'h2400);
    man_en = 1'b0;
    @(negedge clk);
    check("r0_a", a, 0);
    check("r0_b", b, 0);
    check("r0_rd", rd, 1);
    cyc();
    auto_wb = 1'b1;
    cyc();

    // Asynchronous reset while an instruction is held
    out_ready = 1'b0;
    send(16'h2CA0);
    #1 reset = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_illegal", illegal, 0);
    check("arst_cmd", EXE_CMD, NOP);
    @(posedge clk);
    #2 reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("arst_in_ready", in_ready, 1);
    cyc();
    send(16'h2CA0);
    @(negedge clk);
    check("arst_add_a", a, 0);
    check("arst_add_b", b, 0);
    check("arst_add_rd", rd, 3);
    cyc();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: n, default 8, datapath width of register file, operands and writeback data.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: instr  input  16  instruction word, qualified by in_valid.
REQ-005 Port: in_valid  input  1  upstream offers instr.
REQ-006 Port: in_ready  output  1  stage accepts instr this cycle.
REQ-007 Port: a  output  n  ALU operand a (registered).
REQ-008 Port: b  output  n  ALU operand b (registered).
REQ-009 Port: EXE_CMD  output  3  ALU function code (registered), team ALU code encodings.
REQ-010 Port: rd  output  3  destination register of the issued instruction (registered).
REQ-011 Port: out_valid  output  1  a/b/EXE_CMD/rd hold a valid instruction.
REQ-012 Port: out_ready  input  1  downstream consumes the issued instruction.
REQ-013 Port: wb_en, wb_addr, wb_data  input  1/3/n  register-file write port.
REQ-014 Port: illegal  output  1  sticky flag, an illegal opcode was accepted.

Function
REQ-015 Fields: opcode=instr[15:13], rd=[12:10], rs1=[9:7], rs2=[6:4], imm=[7:0].
REQ-016 Opcode map: 000 NOP, 001 ADD, 010 SUB, 011 SLL, 100 SRL, 101 LDI, 110/111 illegal.
REQ-017 ALU ops: a=R[rs1], b=R[rs2], EXE_CMD = matching ALU code (RADD/RSUB/RSLL/RSRL).
REQ-018 LDI: a=imm zero-extended to n, b=0, EXE_CMD=RADD, reads no source.
REQ-019 NOP and illegal: issued as EXE_CMD=NOP, a=b=0, rd=0; illegal also sets illegal=1 until reset.
REQ-020 Register file: 8 x n; R0 reads 0 always; write at rising edge when wb_en and wb_addr!=0.
REQ-021 Accept: transfer when in_valid && in_ready; outputs load next edge, out_valid=1; latency 1 cycle.
REQ-022 in_ready = (!out_valid || out_ready) && !stall.
REQ-023 out_valid clears on out_ready with no new accept the same cycle; outputs hold stable while out_valid && !out_ready.
REQ-024 System contract: downstream asserts wb_en, wb_addr=rd, wb_data=ALU result in the cycle out_valid && out_ready for ADD/SUB/SLL/SRL/LDI.
REQ-025 Sources never compare against R0; unread sources (NOP, LDI, illegal) never cause a stall.
REQ-026 Simultaneous wb_en and a read of the same register: read sees behaviour per REQ-029/030; no other ordering is permitted.

Reset
REQ-027 On reset: out_valid=0, a=b=0, EXE_CMD=NOP, rd=0, illegal=0, all registers 0; in_ready=1 from first cycle after release.
REQ-028 Reset asserted mid-operation discards the issued instruction immediately (asynchronous), no writeback implied.

Configuration
REQ-029 Macro DECODE_FWD_EN defined: source equal to wb_addr with wb_en takes wb_data (bypass); stall only when out_valid && !out_ready && source==rd output.
REQ-030 Macro DECODE_FWD_EN undefined: stall when (out_valid && source==rd output) or (wb_en && source==wb_addr); register file read returns pre-write value.

Structure
REQ-031 Shared package decode_pkg: opcode enumeration, instruction field bit positions, register count.
REQ-032 EXE_CMD encodings come from the team's shared ALU code definitions, never redefined locally.
REQ-033 Register file is one sub-module regfile (two read ports, one write port, R0 hardwired).

Verification
REQ-034 Reset: assert reset, release -> out_valid=0, illegal=0, in_ready=1, ADD r3,r1,r2 issues a=0,b=0.
REQ-035 LDI r1,0x05 then ADD r2,r1,r1 back-to-back with contract writeback -> with DECODE_FWD_EN ADD issues next cycle a=b=0x05; without it exactly one stall cycle, then a=b=0x05.
REQ-036 Backpressure: out_ready=0 for 3 cycles after issuing SUB -> a/b/EXE_CMD/rd stable, in_ready=0; out_ready=1 -> next instruction accepted same cycle.
REQ-037 Opcode 110 accepted -> EXE_CMD=NOP, rd=0, illegal=1 and stays 1 across later legal instructions until reset.
REQ-038 wb_en=1, wb_addr=0, wb_data=0xAA then ADD r1,r0,r0 -> a=b=0.
REQ-039 Reset asserted while out_valid=1 and out_ready=0 -> out_valid=0 before next clock edge; illegal cleared.
